// File: rtl/axis_rr_arb_mux.sv
// rtl/axis_rr_arb_mux.sv - round-robin AXI-Stream arbiter/mux with source-index tagging
// Define AXIS_ARB_FRAME_LOCK_EN to hold the grant until the granted source's tlast beat.
module axis_rr_arb_mux #(
  parameter int S_COUNT    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int USER_WIDTH = 1,
  localparam int SEL_WIDTH = $clog2(S_COUNT)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [S_COUNT*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [S_COUNT-1:0]            s_axis_tvalid,
  output logic [S_COUNT-1:0]            s_axis_tready,
  input  logic [S_COUNT-1:0]            s_axis_tlast,
  input  logic [S_COUNT*USER_WIDTH-1:0] s_axis_tuser,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  output logic [USER_WIDTH-1:0]         m_axis_tuser,
  output logic [SEL_WIDTH-1:0]          m_axis_tid,
  output logic [S_COUNT-1:0]            grant,
  output logic                          busy
);

  typedef enum logic {IDLE = 1'b0, GRANTED = 1'b1} state_t;

  state_t               state;
  logic [SEL_WIDTH-1:0] sel;
  logic [SEL_WIDTH-1:0] rr_ptr;
  logic [SEL_WIDTH-1:0] pick;
  logic [SEL_WIDTH-1:0] next_ptr;
  logic [SEL_WIDTH:0]   idx;
  logic                 pick_valid;
  logic                 out_ready;
  logic                 accept;
  logic                 release_grant;

  // Circular search starting at rr_ptr; the extra index bit absorbs the wrap before reduction.
  always_comb begin
    pick_valid = 1'b0;
    pick       = rr_ptr;
    idx        = '0;
    for (int k = 0; k < S_COUNT; k++) begin
      idx = {1'b0, rr_ptr} + (SEL_WIDTH+1)'(k);
      if (idx >= (SEL_WIDTH+1)'(S_COUNT))
        idx = idx - (SEL_WIDTH+1)'(S_COUNT);
      if (!pick_valid && s_axis_tvalid[idx[SEL_WIDTH-1:0]]) begin
        pick_valid = 1'b1;
        pick       = idx[SEL_WIDTH-1:0];
      end
    end
  end

  assign out_ready = !m_axis_tvalid || m_axis_tready;
  assign accept    = (state == GRANTED) && s_axis_tvalid[sel] && out_ready;
  assign next_ptr  = (sel == SEL_WIDTH'(S_COUNT-1)) ? '0 : sel + SEL_WIDTH'(1);
  assign busy      = |grant;

`ifdef AXIS_ARB_FRAME_LOCK_EN
  assign release_grant = accept && s_axis_tlast[sel];
`else
  assign release_grant = accept;
`endif

  always_comb begin
    s_axis_tready = '0;
    if (state == GRANTED)
      s_axis_tready[sel] = out_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      sel           <= '0;
      rr_ptr        <= '0;
      grant         <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tuser  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tid    <= '0;
    end else begin
      // Load wins over unload so a simultaneous take-and-refill keeps full throughput.
      if (accept) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= s_axis_tdata[sel*DATA_WIDTH +: DATA_WIDTH];
        m_axis_tuser  <= s_axis_tuser[sel*USER_WIDTH +: USER_WIDTH];
        m_axis_tlast  <= s_axis_tlast[sel];
        m_axis_tid    <= sel;
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (pick_valid) begin
            state <= GRANTED;
            sel   <= pick;
            grant <= S_COUNT'(1) << pick;
          end
        end
        GRANTED: begin
          if (release_grant) begin
            state  <= IDLE;
            grant  <= '0;
            rr_ptr <= next_ptr;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_rr_arb_mux.sv
// tb/tb_axis_rr_arb_mux.sv - self-checking bench for axis_rr_arb_mux
// Honours AXIS_ARB_FRAME_LOCK_EN when choosing expected orderings.
module tb_axis_rr_arb_mux;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int UW = 1;
  localparam int SW = 2;
`ifdef AXIS_ARB_FRAME_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N*DW-1:0] s_axis_tdata = '0;
  logic [N-1:0]  s_axis_tvalid = '0;
  logic [N-1:0]  s_axis_tready;
  logic [N-1:0]  s_axis_tlast = '0;
  logic [N*UW-1:0] s_axis_tuser = '0;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b1;
  logic          m_axis_tlast;
  logic [UW-1:0] m_axis_tuser;
  logic [SW-1:0] m_axis_tid;
  logic [N-1:0]  grant;
  logic          busy;

  axis_rr_arb_mux #(.S_COUNT(N), .DATA_WIDTH(DW), .USER_WIDTH(UW)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser), .m_axis_tid(m_axis_tid),
    .grant(grant), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0]  tv;
    logic          mr;
    logic [N-1:0]  gnt;
    logic [N-1:0]  rdy;
    logic          mv;
    logic [SW-1:0] tid;
  } vec_t;

  typedef struct {
    int         tid;
    logic [9:0] beat;
    int         cyc;
  } obeat_t;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  bit auto_en = 1'b0;
  bit rand_valid = 1'b0;
  bit mr_rand = 1'b0;
  bit sb_en = 1'b0;
  logic mr_val = 1'b1;

  // beat encoding {last, user, data}
  logic [9:0] srcq [N][$];
  logic [9:0] expq [N][$];
  obeat_t     outq [$];

  int m_ptr = 0;
  int m_owner = -1;
  int m_exp = 0;
  bit m_have = 1'b0;
  bit prev_open = 1'b0;
  int prev_tid = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  function automatic int rr_pick(input int ptr, input logic [N-1:0] v);
    for (int k = 0; k < N; k++)
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  task automatic tick_begin();
    logic [9:0] b;
    @(negedge clk);
    rst = 1'b0;
    m_axis_tready = mr_rand ? ($urandom_range(3) != 0) : mr_val;
    if (auto_en)
      for (int i = 0; i < N; i++) begin
        if (srcq[i].size() > 0) begin
          b = srcq[i][0];
          s_axis_tdata[i*DW +: DW] = b[7:0];
          s_axis_tuser[i] = b[8];
          s_axis_tlast[i] = b[9];
          s_axis_tvalid[i] = !rand_valid || ($urandom_range(3) != 0);
        end else begin
          s_axis_tvalid[i] = 1'b0;
        end
      end
  endtask

  // Observes the settled cycle: these are the values the next rising edge will act on.
  task automatic tick_end();
    logic [9:0] b;
    obeat_t     o;
    int         t;
    #1;
    cyc++;
    if (rst) begin
      m_ptr = 0; m_owner = -1; m_have = 1'b0; prev_open = 1'b0;
    end else begin
      if (auto_en)
        for (int i = 0; i < N; i++)
          if (s_axis_tvalid[i] && s_axis_tready[i] && srcq[i].size() > 0) b = srcq[i].pop_front();

      if (m_axis_tvalid && m_axis_tready) begin
        t = int'(m_axis_tid);
        o.tid = t; o.beat = {m_axis_tlast, m_axis_tuser, m_axis_tdata}; o.cyc = cyc;
        outq.push_back(o);
        if (sb_en) begin
          if (expq[t].size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL sb_extra_beat: got beat 0x%0h from tid %0d, required none", o.beat, t);
          end else begin
            b = expq[t].pop_front();
            check($sformatf("sb_beat_tid%0d", t), o.beat, b);
          end
          if (LOCK && prev_open) check("no_interleave", t, prev_tid);
          prev_open = !m_axis_tlast;
          prev_tid = t;
        end
      end

      if (m_have) begin
        check("rr_grant", grant, 1 << m_exp);
        m_owner = m_exp;
        m_have = 1'b0;
      end
      if (m_owner >= 0) begin
        check("ready_granted", s_axis_tready, (!m_axis_tvalid || m_axis_tready) ? (1 << m_owner) : 0);
        if (s_axis_tvalid[m_owner] && (!m_axis_tvalid || m_axis_tready) && (!LOCK || s_axis_tlast[m_owner])) begin
          m_ptr = (m_owner + 1) % N;
          m_owner = -1;
        end
      end else begin
        check("ready_idle", s_axis_tready, 0);
        check("grant_idle", grant, 0);
        if (|s_axis_tvalid) begin
          m_exp = rr_pick(m_ptr, s_axis_tvalid);
          m_have = 1'b1;
        end
      end
    end
  endtask

  task automatic tick();
    tick_begin();
    tick_end();
  endtask

  task automatic reset_dut();
    auto_en = 1'b0; rand_valid = 1'b0; mr_rand = 1'b0; sb_en = 1'b0; mr_val = 1'b1;
    tick_begin();
    rst = 1'b1;
    s_axis_tvalid = '0;
    tick_end();
    for (int i = 0; i < N; i++) begin
      srcq[i].delete();
      expq[i].delete();
    end
    outq.delete();
  endtask

  task automatic push_beat(input int p, input logic [7:0] d, input logic last, input logic user);
    srcq[p].push_back({last, user, d});
    expq[p].push_back({last, user, d});
  endtask

  task automatic wait_out(input int n, input int budget, input string name);
    int c;
    c = 0;
    while (outq.size() < n && c < budget) begin
      tick();
      c++;
    end
    check({name, "_beats_seen"}, outq.size() >= n, 1);
  endtask

  function automatic int exp_total();
    int s;
    s = 0;
    for (int i = 0; i < N; i++) s += expq[i].size();
    return s;
  endfunction

  vec_t vecs [15];
  logic [7:0] exp_d [4];
  int exp_t [4];
  logic [9:0] ob;
  logic [7:0] held;
  bit have_hold;
  int stalled;
  int gap;

  initial begin
    // single-beat frames on every port, so the table holds in both grant modes
    vecs[0]  = '{4'hF, 1'b1, 4'h0, 4'h0, 1'b0, 2'd0};
    vecs[1]  = '{4'hF, 1'b1, 4'h1, 4'h1, 1'b0, 2'd0};
    vecs[2]  = '{4'hF, 1'b1, 4'h0, 4'h0, 1'b1, 2'd0};
    vecs[3]  = '{4'hF, 1'b1, 4'h2, 4'h2, 1'b0, 2'd0};
    vecs[4]  = '{4'h9, 1'b1, 4'h0, 4'h0, 1'b1, 2'd1};
    vecs[5]  = '{4'h9, 1'b1, 4'h8, 4'h8, 1'b0, 2'd0};
    vecs[6]  = '{4'h2, 1'b1, 4'h0, 4'h0, 1'b1, 2'd3};
    vecs[7]  = '{4'h0, 1'b1, 4'h2, 4'h2, 1'b0, 2'd0};
    vecs[8]  = '{4'h4, 1'b0, 4'h2, 4'h2, 1'b0, 2'd0};
    vecs[9]  = '{4'h2, 1'b0, 4'h2, 4'h2, 1'b0, 2'd0};
    vecs[10] = '{4'h1, 1'b0, 4'h0, 4'h0, 1'b1, 2'd1};
    vecs[11] = '{4'h1, 1'b0, 4'h1, 4'h0, 1'b1, 2'd1};
    vecs[12] = '{4'h1, 1'b1, 4'h1, 4'h1, 1'b1, 2'd1};
    vecs[13] = '{4'h0, 1'b1, 4'h0, 4'h0, 1'b1, 2'd0};
    vecs[14] = '{4'h0, 1'b1, 4'h0, 4'h0, 1'b0, 2'd0};

    // reset held two cycles with every source requesting
    tick_begin(); rst = 1'b1; s_axis_tvalid = '1; tick_end();
    tick_begin(); rst = 1'b1; s_axis_tvalid = '1; tick_end();
    check("rst_grant", grant, 0);
    check("rst_mvalid", m_axis_tvalid, 0);
    check("rst_sready", s_axis_tready, 0);
    check("rst_busy", busy, 0);
    check("rst_out_fields", {m_axis_tdata, m_axis_tuser, m_axis_tid, m_axis_tlast}, 0);
    tick_begin(); s_axis_tvalid = '1; tick_end();
    check("post_rst_idle_grant", grant, 0);
    check("post_rst_idle_sready", s_axis_tready, 0);
    tick_begin(); s_axis_tvalid = '1; tick_end();
    check("first_grant_port0", grant, 4'h1);
    check("first_ready_port0", s_axis_tready, 4'h1);

    // table-driven single-beat arbitration, stall and skip cases
    tick_begin();
    rst = 1'b1;
    s_axis_tvalid = '0;
    s_axis_tdata = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    s_axis_tuser = 4'b1010;
    s_axis_tlast = 4'hF;
    tick_end();
    for (int r = 0; r < 15; r++) begin
      tick_begin();
      s_axis_tvalid = vecs[r].tv;
      m_axis_tready = vecs[r].mr;
      tick_end();
      check($sformatf("t%0d_grant", r), grant, vecs[r].gnt);
      check($sformatf("t%0d_sready", r), s_axis_tready, vecs[r].rdy);
      check($sformatf("t%0d_mvalid", r), m_axis_tvalid, vecs[r].mv);
      check($sformatf("t%0d_busy", r), busy, |vecs[r].gnt);
      if (vecs[r].mv) begin
        check($sformatf("t%0d_tid", r), m_axis_tid, vecs[r].tid);
        check($sformatf("t%0d_tdata", r), m_axis_tdata, 8'hA0 + vecs[r].tid);
        check($sformatf("t%0d_tuser", r), m_axis_tuser, vecs[r].tid[0]);
        check($sformatf("t%0d_tlast", r), m_axis_tlast, 1);
      end
    end

    // single source: 3-beat frame from port 2
    reset_dut();
    sb_en = 1'b1; auto_en = 1'b1;
    push_beat(2, 8'h11, 1'b0, 1'b0);
    push_beat(2, 8'h22, 1'b0, 1'b1);
    push_beat(2, 8'h33, 1'b1, 1'b0);
    wait_out(3, 40, "single");
    exp_d = '{8'h11, 8'h22, 8'h33, 8'h00};
    gap = LOCK ? 1 : 2;
    for (int k = 0; k < 3; k++)
      if (outq.size() > k) begin
        ob = outq[k].beat;
        check($sformatf("single_data%0d", k), ob[7:0], exp_d[k]);
        check($sformatf("single_last%0d", k), ob[9], k == 2);
        check($sformatf("single_tid%0d", k), outq[k].tid, 2);
        if (k > 0) check($sformatf("single_gap%0d", k), outq[k].cyc - outq[k-1].cyc, gap);
      end
    tick(); tick();
    check("single_busy_after", busy, 0);

    // fairness: all ports stream two 2-beat frames
    reset_dut();
    sb_en = 1'b1; auto_en = 1'b1;
    for (int p = 0; p < N; p++)
      for (int f = 0; f < 2; f++)
        for (int b = 0; b < 2; b++)
          push_beat(p, 8'(p*16 + f*4 + b), b == 1, 1'(b));
    wait_out(16, 200, "fair");
    for (int k = 0; k < 16; k++)
      if (outq.size() > k) check($sformatf("fair_tid%0d", k), outq[k].tid, LOCK ? (k/2) % N : k % N);

    // backpressure: stall the output for 5 cycles mid-frame
    reset_dut();
    sb_en = 1'b1; auto_en = 1'b1;
    for (int k = 0; k < 6; k++) push_beat(1, 8'h40 + 8'(k), k == 5, 1'b0);
    wait_out(2, 40, "bp_pre");
    mr_val = 1'b0;
    have_hold = 1'b0; stalled = 0; held = '0;
    for (int c = 0; c < 30 && stalled < 5; c++) begin
      tick();
      if (have_hold) begin
        check("bp_tdata_stable", m_axis_tdata, held);
        check("bp_mvalid_held", m_axis_tvalid, 1);
        check("bp_sready_low", s_axis_tready[1], 0);
        stalled++;
      end else if (m_axis_tvalid) begin
        held = m_axis_tdata;
        have_hold = 1'b1;
      end
    end
    check("bp_stall_cycles", stalled, 5);
    mr_val = 1'b1;
    wait_out(6, 60, "bp_post");
    tick(); tick(); tick();
    check("bp_beat_count", outq.size(), 6);
    check("bp_all_delivered", exp_total(), 0);

    // two sources, two beats each
    reset_dut();
    sb_en = 1'b1; auto_en = 1'b1;
    push_beat(1, 8'hA1, 1'b0, 1'b0);
    push_beat(1, 8'hA2, 1'b1, 1'b0);
    push_beat(3, 8'hB1, 1'b0, 1'b1);
    push_beat(3, 8'hB2, 1'b1, 1'b1);
    wait_out(4, 60, "pair");
    if (LOCK) begin
      exp_d = '{8'hA1, 8'hA2, 8'hB1, 8'hB2};
      exp_t = '{1, 1, 3, 3};
    end else begin
      exp_d = '{8'hA1, 8'hB1, 8'hA2, 8'hB2};
      exp_t = '{1, 3, 1, 3};
    end
    for (int k = 0; k < 4; k++)
      if (outq.size() > k) begin
        ob = outq[k].beat;
        check($sformatf("pair_data%0d", k), ob[7:0], exp_d[k]);
        check($sformatf("pair_tid%0d", k), outq[k].tid, exp_t[k]);
      end

    // reset after the first beat of a 3-beat frame from port 0
    reset_dut();
    sb_en = 1'b1; auto_en = 1'b1;
    push_beat(0, 8'hC1, 1'b0, 1'b0);
    push_beat(0, 8'hC2, 1'b0, 1'b0);
    push_beat(0, 8'hC3, 1'b1, 1'b0);
    wait_out(1, 20, "midrst_pre");
    auto_en = 1'b0; sb_en = 1'b0;
    tick_begin(); rst = 1'b1; s_axis_tvalid = '0; m_axis_tready = 1'b0; tick_end();
    for (int i = 0; i < N; i++) begin
      srcq[i].delete();
      expq[i].delete();
    end
    outq.delete();
    tick();
    check("midrst_mvalid", m_axis_tvalid, 0);
    check("midrst_grant", grant, 0);
    check("midrst_busy", busy, 0);
    sb_en = 1'b1; auto_en = 1'b1;
    push_beat(0, 8'hD0, 1'b1, 1'b0);
    push_beat(1, 8'hD1, 1'b1, 1'b1);
    wait_out(2, 30, "midrst_post");
    if (outq.size() > 1) begin
      check("midrst_first_tid", outq[0].tid, 0);
      check("midrst_second_tid", outq[1].tid, 1);
    end

    // randomized traffic against the scoreboard and round-robin model
    reset_dut();
    sb_en = 1'b1; auto_en = 1'b1; rand_valid = 1'b1; mr_rand = 1'b1;
    for (int f = 0; f < 40; f++) begin
      int p;
      int len;
      p = $urandom_range(N-1);
      len = $urandom_range(4, 1);
      for (int b = 0; b < len; b++)
        push_beat(p, 8'($urandom), b == len-1, 1'($urandom));
    end
    for (int c = 0; c < 4000 && exp_total() > 0; c++) tick();
    check("rand_drained", exp_total(), 0);
    rand_valid = 1'b0; mr_rand = 1'b0;
    tick(); tick(); tick();
    check("rand_idle_busy", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
